mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: turns EX/MEM load/store requests into single-beat bus cycles and formats load data.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic [31:0] memOut,
  output logic        stall,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  output logic [3:0]  busBe,
  input  logic [31:0] busRData,
  input  logic        busAck,
  output logic        busError,
  output logic        misaligned
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] memOut_q, memOut_d;
  logic        busReq_q, busReq_d;
  logic        busWe_q, busWe_d;
  logic [31:0] busAddr_q, busAddr_d;
  logic [31:0] busWData_q, busWData_d;
  logic [3:0]  busBe_q, busBe_d;
  logic        busError_q, busError_d;
  logic        misaligned_q, misaligned_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;

  logic        access_s;
  logic        trap_s;
  logic [1:0]  eoff_s;
  logic [7:0]  cnt_next_s;

  // Byte lane actually used; half ignores addr[0] and word ignores addr[1:0].
  function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   eff_offset = a;
      2'b01:   eff_offset = {a[1], 1'b0};
      default: eff_offset = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   byte_enables = 4'b0001 << off;
      2'b01:   byte_enables = 4'b0011 << off;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   store_lanes = {4{data[7:0]}};
      2'b01:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [1:0] size, input logic [1:0] off,
                                              input logic uns, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00: begin
        if (uns) begin
          load_format = {24'h000000, sh[7:0]};
        end else begin
          load_format = {{24{sh[7]}}, sh[7:0]};
        end
      end
      2'b01: begin
        if (uns) begin
          load_format = {16'h0000, sh[15:0]};
        end else begin
          load_format = {{16{sh[15]}}, sh[15:0]};
        end
      end
      default: load_format = sh;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  assign trap_s = access_s & is_misaligned(memSize, addr[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  assign access_s   = memRead | memWrite;
  assign eoff_s     = eff_offset(memSize, addr[1:0]);
  assign cnt_next_s = (cnt_q == TIMEOUT_C) ? cnt_q : (cnt_q + 8'd1);

  // Upstream must freeze from the request cycle until the result cycle.
  assign stall = ~reset & (((state_q == S_IDLE) & access_s) | (state_q == S_REQ));

  assign memOut     = memOut_q;
  assign busReq     = busReq_q;
  assign busWe      = busWe_q;
  assign busAddr    = busAddr_q;
  assign busWData   = busWData_q;
  assign busBe      = busBe_q;
  assign busError   = busError_q;
  assign misaligned = misaligned_q;

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    memOut_d     = memOut_q;
    busReq_d     = busReq_q;
    busWe_d      = busWe_q;
    busAddr_d    = busAddr_q;
    busWData_d   = busWData_q;
    busBe_d      = busBe_q;
    busError_d   = 1'b0;
    misaligned_d = 1'b0;
    size_d       = size_q;
    off_d        = off_q;
    uns_d        = uns_q;
    case (state_q)
      S_IDLE: begin
        if (access_s) begin
          if (trap_s) begin
            state_d      = S_DONE;
            memOut_d     = 32'h00000000;
            misaligned_d = 1'b1;
            busReq_d     = 1'b0;
          end else begin
            state_d    = S_REQ;
            busReq_d   = 1'b1;
            busWe_d    = memWrite;
            busAddr_d  = {addr[31:2], 2'b00};
            busBe_d    = byte_enables(memSize, eoff_s);
            busWData_d = store_lanes(memSize, storeData);
            size_d     = memSize;
            off_d      = eoff_s;
            uns_d      = memUnsigned;
            cnt_d      = 8'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (busAck) begin
          state_d  = S_DONE;
          busReq_d = 1'b0;
          memOut_d = busWe_q ? 32'h00000000 : load_format(size_q, off_q, uns_q, busRData);
        end else if (cnt_next_s == TIMEOUT_C) begin
          state_d    = S_ERR;
          busReq_d   = 1'b0;
          busError_d = 1'b1;
          memOut_d   = 32'h00000000;
          cnt_d      = cnt_next_s;
        end else begin
          state_d = S_REQ;
          cnt_d   = cnt_next_s;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      memOut_q     <= 32'h00000000;
      busReq_q     <= 1'b0;
      busWe_q      <= 1'b0;
      busAddr_q    <= 32'h00000000;
      busWData_q   <= 32'h00000000;
      busBe_q      <= 4'b0000;
      busError_q   <= 1'b0;
      misaligned_q <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      memOut_q     <= memOut_d;
      busReq_q     <= busReq_d;
      busWe_q      <= busWe_d;
      busAddr_q    <= busAddr_d;
      busWData_q   <= busWData_d;
      busBe_q      <= busBe_d;
      busError_q   <= busError_d;
      misaligned_q <= misaligned_d;
      size_q       <= size_d;
      off_q        <= off_d;
      uns_q        <= uns_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (bus slave modelled inline; inputs driven and outputs sampled off the rising edge).
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        memRead, memWrite, memUnsigned;
  logic [1:0]  memSize;
  logic [31:0] addr, storeData;
  logic [31:0] memOut;
  logic        stall, busReq, busWe;
  logic [31:0] busAddr, busWData;
  logic [3:0]  busBe;
  logic [31:0] busRData;
  logic        busAck;
  logic        busError, misaligned;

  int cmp_count = 0;
  int err_count = 0;

  int          obs_stalls, obs_reqs, obs_err, obs_mis;
  logic        obs_done, obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_out, obs_hold;
  logic [3:0]  obs_be;

  mem_stage #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .memSize(memSize), .memUnsigned(memUnsigned), .addr(addr), .storeData(storeData),
    .memOut(memOut), .stall(stall), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busWData(busWData), .busBe(busBe), .busRData(busRData), .busAck(busAck),
    .busError(busError), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  // Drives one access and plays the bus slave: ack in the REQ cycle with index ack_after (-1 = never).
  task automatic bus_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                            input int ack_after);
    memRead = rd; memWrite = wr; memSize = sz; memUnsigned = uns; addr = a; storeData = sd;
    busAck = 1'b0; busRData = 32'h0;
    obs_stalls = 0; obs_reqs = 0; obs_err = 0; obs_mis = 0; obs_done = 1'b0;
    obs_addr = 32'h0; obs_wdata = 32'h0; obs_be = 4'h0; obs_we = 1'b0; obs_out = 32'h0;
    for (int cyc = 0; cyc < 60 && !obs_done; cyc++) begin
      #1;
      if (busError) obs_err++;
      if (misaligned) obs_mis++;
      if (cyc > 0 && !stall) begin
        obs_done = 1'b1; obs_out = memOut;
        memRead = 1'b0; memWrite = 1'b0; busAck = 1'b0;
      end else begin
        if (stall) obs_stalls++;
        if (busReq) begin
          if (obs_reqs == 0) begin
            obs_addr = busAddr; obs_wdata = busWData; obs_be = busBe; obs_we = busWe;
          end
          busAck = (obs_reqs == ack_after); busRData = rdata;
          obs_reqs++;
        end else begin
          busAck = 1'b0;
        end
      end
      @(negedge clock);
    end
    memRead = 1'b0; memWrite = 1'b0; busAck = 1'b0;
    #1;
    obs_hold = memOut;
    if (busError) obs_err++;
    if (misaligned) obs_mis++;
  endtask

  task automatic test_reset;
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; memSize = 2'b00; memUnsigned = 1'b0;
    addr = 32'h0; storeData = 32'h0; busRData = 32'h0; busAck = 1'b0;
    repeat (2) @(negedge clock);
    memRead = 1'b1; #1;
    cmp_count++; if (stall !== 1'b0) begin err_count++; $display("FAIL rst_stall got=%b exp=0", stall); end
    memRead = 1'b0;
    cmp_count++; if (memOut !== 32'h0) begin err_count++; $display("FAIL rst_memOut got=%h exp=00000000", memOut); end
    cmp_count++; if ({busReq, busWe, busError, misaligned, busBe} !== 8'h00) begin err_count++;
      $display("FAIL rst_ctrl got=%b exp=00000000", {busReq, busWe, busError, misaligned, busBe}); end
    cmp_count++; if ({busAddr, busWData} !== 64'h0) begin err_count++;
      $display("FAIL rst_bus got=%h exp=0", {busAddr, busWData}); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_word_load;
    bus_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000100, 32'h0, 32'hDEADBEEF, 1);
    cmp_count++; if (obs_done !== 1'b1) begin err_count++; $display("FAIL wl_done got=%b exp=1", obs_done); end
    cmp_count++; if (obs_out !== 32'hDEADBEEF) begin err_count++; $display("FAIL wl_out got=%h exp=deadbeef", obs_out); end
    cmp_count++; if (obs_stalls !== 3) begin err_count++; $display("FAIL wl_stalls got=%0d exp=3", obs_stalls); end
    cmp_count++; if ({obs_addr, obs_be, obs_we} !== {32'h00000100, 4'b1111, 1'b0}) begin err_count++;
      $display("FAIL wl_bus got=%h/%b/%b exp=00000100/1111/0", obs_addr, obs_be, obs_we); end
    cmp_count++; if (obs_hold !== 32'hDEADBEEF) begin err_count++; $display("FAIL wl_hold got=%h exp=deadbeef", obs_hold); end
    bus_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0, 32'hCAFEF00D, 0);
    cmp_count++; if ({obs_out, obs_stalls[7:0]} !== {32'hCAFEF00D, 8'd2}) begin err_count++;
      $display("FAIL wl_zero_wait got=%h/%0d exp=cafef00d/2", obs_out, obs_stalls); end
  endtask

  task automatic test_sub_word_load;
    bus_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h00000103, 32'h0, 32'h80000000, 0);
    cmp_count++; if (obs_out !== 32'hFFFFFF80) begin err_count++; $display("FAIL lb_signed got=%h exp=ffffff80", obs_out); end
    cmp_count++; if (obs_be !== 4'b1000) begin err_count++; $display("FAIL lb_be got=%b exp=1000", obs_be); end
    bus_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h00000103, 32'h0, 32'h80000000, 0);
    cmp_count++; if (obs_out !== 32'h00000080) begin err_count++; $display("FAIL lb_unsigned got=%h exp=00000080", obs_out); end
    bus_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h00000002, 32'h0, 32'h80010000, 2);
    cmp_count++; if (obs_out !== 32'hFFFF8001) begin err_count++; $display("FAIL lh_signed got=%h exp=ffff8001", obs_out); end
    bus_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h00000000, 32'h0, 32'h12348765, 0);
    cmp_count++; if (obs_out !== 32'h00008765) begin err_count++; $display("FAIL lh_unsigned got=%h exp=00008765", obs_out); end
  endtask

  task automatic test_store;
    bus_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h00000202, 32'h1234ABCD, 32'hFFFFFFFF, 0);
    cmp_count++; if (obs_be !== 4'b1100) begin err_count++; $display("FAIL sh_be got=%b exp=1100", obs_be); end
    cmp_count++; if (obs_wdata !== 32'hABCDABCD) begin err_count++; $display("FAIL sh_wdata got=%h exp=abcdabcd", obs_wdata); end
    cmp_count++; if ({obs_addr, obs_we} !== {32'h00000200, 1'b1}) begin err_count++;
      $display("FAIL sh_addr_we got=%h/%b exp=00000200/1", obs_addr, obs_we); end
    cmp_count++; if (obs_out !== 32'h0) begin err_count++; $display("FAIL sh_memOut got=%h exp=00000000", obs_out); end
    bus_access(1'b1, 1'b1, 2'b00, 1'b0, 32'h00000001, 32'h0000005A, 32'h12345678, 0);
    cmp_count++; if ({obs_we, obs_be, obs_wdata} !== {1'b1, 4'b0010, 32'h5A5A5A5A}) begin err_count++;
      $display("FAIL sb_rw_write got=%b/%b/%h exp=1/0010/5a5a5a5a", obs_we, obs_be, obs_wdata); end
  endtask

  task automatic test_timeout;
    bus_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 32'h55555555, -1);
    cmp_count++; if (obs_done !== 1'b1) begin err_count++; $display("FAIL to_done got=%b exp=1", obs_done); end
    cmp_count++; if (obs_reqs !== 16) begin err_count++; $display("FAIL to_req_cycles got=%0d exp=16", obs_reqs); end
    cmp_count++; if (obs_err !== 1) begin err_count++; $display("FAIL to_error_pulses got=%0d exp=1", obs_err); end
    cmp_count++; if ({obs_out, obs_stalls[7:0]} !== {32'h0, 8'd17}) begin err_count++;
      $display("FAIL to_out_stalls got=%h/%0d exp=00000000/17", obs_out, obs_stalls); end
    bus_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000304, 32'h0, 32'h0BADF00D, 0);
    cmp_count++; if ({obs_out, obs_err[7:0]} !== {32'h0BADF00D, 8'd0}) begin err_count++;
      $display("FAIL to_recover got=%h/%0d exp=0badf00d/0", obs_out, obs_err); end
  endtask

  task automatic test_reset_in_req;
    @(negedge clock);
    memRead = 1'b1; memWrite = 1'b0; memSize = 2'b10; addr = 32'h00000040;
    @(negedge clock); #1;
    cmp_count++; if (busReq !== 1'b1) begin err_count++; $display("FAIL rr_in_req got=%b exp=1", busReq); end
    reset = 1'b1;
    @(negedge clock); #1;
    cmp_count++; if ({busReq, stall, memOut} !== 34'h0) begin err_count++;
      $display("FAIL rr_cleared got=%b/%b/%h exp=0/0/00000000", busReq, stall, memOut); end
    reset = 1'b0; memRead = 1'b0; busAck = 1'b1; busRData = 32'h11111111;
    @(negedge clock); #1;
    cmp_count++; if ({busReq, stall, memOut} !== 34'h0) begin err_count++;
      $display("FAIL rr_late_ack got=%b/%b/%h exp=0/0/00000000", busReq, stall, memOut); end
    busAck = 1'b0;
    bus_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000044, 32'h0, 32'h55667788, 0);
    cmp_count++; if ({obs_out, obs_stalls[7:0]} !== {32'h55667788, 8'd2}) begin err_count++;
      $display("FAIL rr_next_access got=%h/%0d exp=55667788/2", obs_out, obs_stalls); end
  endtask

  task automatic test_misaligned;
    bus_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000101, 32'h0, 32'hA1B2C3D4, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    cmp_count++; if (obs_mis !== 1) begin err_count++; $display("FAIL ma_pulse got=%0d exp=1", obs_mis); end
    cmp_count++; if (obs_reqs !== 0) begin err_count++; $display("FAIL ma_no_req got=%0d exp=0", obs_reqs); end
    cmp_count++; if (obs_out !== 32'h0) begin err_count++; $display("FAIL ma_memOut got=%h exp=00000000", obs_out); end
`else
    cmp_count++; if ({obs_addr, obs_be} !== {32'h00000100, 4'b1111}) begin err_count++;
      $display("FAIL ma_word got=%h/%b exp=00000100/1111", obs_addr, obs_be); end
    cmp_count++; if ({obs_out, obs_mis[7:0]} !== {32'hA1B2C3D4, 8'd0}) begin err_count++;
      $display("FAIL ma_word_data got=%h/%0d exp=a1b2c3d4/0", obs_out, obs_mis); end
    bus_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h00000003, 32'h0, 32'hA1B2C3D4, 0);
    cmp_count++; if ({obs_be, obs_out} !== {4'b1100, 32'h0000A1B2}) begin err_count++;
      $display("FAIL ma_half got=%b/%h exp=1100/0000a1b2", obs_be, obs_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_sub_word_load();
    test_store();
    test_timeout();
    test_reset_in_req();
    test_misaligned();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
